icache_responder: RTL
=====================

Name: icache_responder

Overview:
- Direct-mapped, one-word-per-line instruction cache. It is the responder side of the fetch unit's cache request interface (en_rx/pcx, en_ry/pcy in; hitx/instx out).
- Serves two lookup ports combinationally.
- On a miss it refills the line from a byte-wide memory port using a request/valid handshake.
- Port y misses are prefetched when port x hits.

Parameters:
- INDEX_BITS, 6, number of index bits; the cache holds 2^INDEX_BITS lines of one 32-bit word each.
- ADDR_W, 32, address width; addr_t equals ADDR_W bits.

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  synchronous reset, active-high
- rdy  in  1  global ready; when low, all state is frozen
- en_rx_in  in  1  port x lookup enable
- pcx_in  in  ADDR_W  port x word address (bits [1:0] ignored)
- en_ry_in  in  1  port y lookup enable
- pcy_in  in  ADDR_W  port y word address
- hitx_out  out  1  port x hit (combinational)
- instx_out  out  32  port x word; byte at addr+0 in [31:24], addr+3 in [7:0]
- hity_out  out  1  port y hit (combinational)
- insty_out  out  32  port y word, same byte order as instx_out
- mem_req_out  out  1  byte read request to memory
- mem_addr_out  out  ADDR_W  byte address of the current request
- mem_valid_in  in  1  memory returns one byte this cycle
- mem_data_in  in  8  returned byte

Behaviour:
Address split
- index = addr[INDEX_BITS+1:2]
- tag = addr[ADDR_W-1:INDEX_BITS+2]

Storage
- valid[], tag[] and data[] arrays.
- rst clears every valid bit. Tag and data arrays are not reset.

Lookup (combinational, zero latency)
- hitx_out = en_rx_in & valid[idx(pcx)] & (tag[idx(pcx)] == tag(pcx)).
- hity_out is the same function applied to port y.
- instx_out/insty_out = data[idx]. Their value is don't-care when the matching hit is 0.

Reset values
- hitx_out = hity_out = 0 (all lines invalid).
- mem_req_out = 0; mem_addr_out = 0; FSM = IDLE; byte counter = 0.

FSM states: IDLE, FILL, COMMIT
- IDLE:
  - If en_rx_in & ~hitx_out: latch line address = pcx_in & ~3, go to FILL.
  - Else if en_rx_in & hitx_out & en_ry_in & ~hity_out: latch pcy_in & ~3 (prefetch), go to FILL.
  - Port x always has priority over port y.
- FILL:
  - mem_req_out = 1; mem_addr_out = line address + counter.
  - Each cycle with mem_valid_in = 1: place mem_data_in into byte lane (3 - counter) of the fill buffer and increment counter.
  - After the beat with counter = 3: go to COMMIT with counter = 0.
  - mem_valid_in while not in FILL is ignored.
- COMMIT:
  - mem_req_out = 0.
  - Write the fill buffer to data[idx], write tag[idx], set valid[idx].
  - Return to IDLE.
  - The refilled line is visible to lookups on the following cycle.
- Miss-to-hit latency: 4 valid beats + 2 cycles minimum (decision cycle, beats, commit).

Boundary conditions
- A pc change during FILL does not abort the fill. The line completes and commits, then IDLE re-evaluates the new pc.
- A conflicting line (same index, different tag) is overwritten at COMMIT. There is no write-back because the cache is read-only.
- Lookups of a different line proceed normally during FILL. Lookups of the line being filled report a miss until after COMMIT.
- pcx and pcy mapping to the same missing line produce a single fill.
- rdy = 0: FSM, counter, buffer and arrays hold their values. mem_req_out holds its value, and bytes arriving are ignored. Lookup outputs stay combinational.
- rst during FILL or COMMIT: return to IDLE, drop the partial line, clear all valid bits; no array write occurs in that cycle.
- Byte address arithmetic wraps modulo 2^ADDR_W.

Test Plan:
- Reset: rst = 1 for 2 cycles -> hitx_out = 0, hity_out = 0, mem_req_out = 0, mem_addr_out = 0.
- Cold miss: en_rx = 1, pcx = 0x0, memory returns 0x13, 0x05, 0x00, 0x00 on consecutive cycles -> mem_addr_out steps 0, 1, 2, 3; the cycle after COMMIT shows hitx_out = 1, instx_out = 0x13050000.
- Prefetch: with 0x0 cached, pcx = 0x0, pcy = 0x4 uncached -> fill issued for 0x4..0x7; afterwards hity_out = 1 with the correct word, and hitx_out stays 1 throughout.
- Conflict: with 0x0 cached, request pcx = 0x100 (same index when INDEX_BITS = 6) -> refill occurs; then pcx = 0x100 gives hitx_out = 1 and pcx = 0x0 gives hitx_out = 0.
- Stall: rdy = 0 after 2 beats for 5 cycles with mem_valid_in pulsed -> those bytes are ignored; after rdy = 1, 2 more beats complete a correct line.
- Reset mid-fill: assert rst after beat 2 -> FSM returns to IDLE, mem_req_out = 0, and the previously valid line 0x0 now misses.

Source files
------------

// File: rtl/icache_responder.sv
// Direct-mapped, one-word-per-line instruction cache with two combinational lookup
// ports and a byte-serial refill engine. A port y miss is prefetched while port x hits.
module icache_responder #(
    parameter int INDEX_BITS = 6,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              en_rx_in,
    input  logic [ADDR_W-1:0] pcx_in,
    input  logic              en_ry_in,
    input  logic [ADDR_W-1:0] pcy_in,
    output logic              hitx_out,
    output logic [31:0]       instx_out,
    output logic              hity_out,
    output logic [31:0]       insty_out,
    output logic              mem_req_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    input  logic              mem_valid_in,
    input  logic [7:0]        mem_data_in
);
    localparam int NUM_PORTS = 2;
    localparam int LINES     = 1 << INDEX_BITS;
    localparam int TAG_W     = ADDR_W - INDEX_BITS - 2;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef enum logic [1:0] {IDLE, FILL, COMMIT} state_t;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    state_t          state, state_nx;
    logic [1:0]      cnt, cnt_nx;
    addr_t           line_addr, line_nx;
    logic [3:0][7:0] fill_buf, buf_nx;

    // Port 0 is x, port 1 is y.
    logic [NUM_PORTS-1:0][ADDR_W-1:0] pc;
    logic [NUM_PORTS-1:0]             en, hit;
    logic [NUM_PORTS-1:0][31:0]       word;

    assign pc = {pcy_in, pcx_in};
    assign en = {en_ry_in, en_rx_in};

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_lookup
        logic [INDEX_BITS-1:0] idx;
        logic [TAG_W-1:0]      tag;
        assign idx     = pc[g][INDEX_BITS+1:2];
        assign tag     = pc[g][ADDR_W-1:INDEX_BITS+2];
        assign hit[g]  = en[g] & valid[idx] & (tag_mem[idx] == tag);
        assign word[g] = data_mem[idx];
    end

    logic unused_low_bits;
    assign unused_low_bits = ^{pc[0][1:0], pc[1][1:0]};

    assign hitx_out  = hit[0];
    assign hity_out  = hit[1];
    assign instx_out = word[0];
    assign insty_out = word[1];

    logic [INDEX_BITS-1:0] line_idx;
    logic [TAG_W-1:0]      line_tag;
    assign line_idx = line_addr[INDEX_BITS+1:2];
    assign line_tag = line_addr[ADDR_W-1:INDEX_BITS+2];

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        line_nx      = line_addr;
        buf_nx       = fill_buf;
        mem_req_out  = 1'b0;
        mem_addr_out = '0;
        unique case (state)
            IDLE: begin
                if (en_rx_in && !hit[0]) begin
                    line_nx  = {pcx_in[ADDR_W-1:2], 2'b00};
                    state_nx = FILL;
                end else if (en_rx_in && hit[0] && en_ry_in && !hit[1]) begin
                    line_nx  = {pcy_in[ADDR_W-1:2], 2'b00};
                    state_nx = FILL;
                end
            end
            FILL: begin
                mem_req_out  = 1'b1;
                mem_addr_out = line_addr + ADDR_W'(cnt);
                if (mem_valid_in) begin
                    // First byte fetched lands in the most significant lane.
                    buf_nx[2'd3 - cnt] = mem_data_in;
                    cnt_nx             = cnt + 2'd1;
                    if (cnt == 2'd3) state_nx = COMMIT;
                end
            end
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            line_addr <= '0;
            valid     <= '0;
        end else if (rdy) begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            line_addr <= line_nx;
            if (state == COMMIT) valid[line_idx] <= 1'b1;
        end
    end

    // Tag/data arrays and the fill buffer carry no reset.
    always_ff @(posedge clk) begin
        if (rdy && !rst) begin
            fill_buf <= buf_nx;
            if (state == COMMIT) begin
                tag_mem[line_idx]  <= line_tag;
                data_mem[line_idx] <= fill_buf;
            end
        end
    end
endmodule
